// File: rtl/ext_link_peer.sv
// Far-end peer for the external serial link: sends packets with the sync/ack/frame/ack
// handshake, answers incoming syncs, deserialises frames and flags handshake timeouts.
module ext_link_peer #(
    parameter int          PACKET_WIDTH   = 10,
    parameter logic [15:0] BAUD_SIZE      = 16'd8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    tx,
    input  logic                    rx,
    input  logic [PACKET_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [PACKET_WIDTH-1:0] r_data,
    output logic                    r_valid,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [15:0]             baud_meas
);

    localparam int BIT_W = $clog2(PACKET_WIDTH + 2);
    localparam logic [BIT_W-1:0] LAST_TX_BIT = BIT_W'(PACKET_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_RX_BIT = BIT_W'(PACKET_WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T_SYNC,
        S_T_ACK1_LO,
        S_T_ACK1_HI,
        S_T_GAP,
        S_T_DATA,
        S_T_ACK2_LO,
        S_T_ACK2_HI,
        S_R_SYNC,
        S_R_ACK1,
        S_R_WAIT_START,
        S_R_HALF,
        S_R_BITS,
        S_R_STOP,
        S_R_ACK2
    } state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             cnt_reg, cnt_next;
    logic [BIT_W-1:0]        bit_reg, bit_next;
    logic [PACKET_WIDTH+1:0] frame_reg, frame_next;
    logic [PACKET_WIDTH-1:0] shift_reg, shift_next;
    logic [PACKET_WIDTH-1:0] r_data_reg, r_data_next;
    logic [15:0]             baud_reg, baud_next;
    logic                    tx_reg, tx_next;
    logic                    r_valid_reg, r_valid_next;
    logic                    err_reg, err_next;
    logic                    rx_meta_reg, rxs_reg;
    logic [PACKET_WIDTH+1:0] frame_load;
    logic                    timed_out;

    // Outgoing frame: start bit, data LSB first, stop bit.
    assign frame_load[0]              = 1'b0;
    assign frame_load[PACKET_WIDTH+1] = 1'b1;
    for (genvar gi = 0; gi < PACKET_WIDTH; gi++) begin : g_frame
        assign frame_load[gi+1] = s_data[gi];
    end

    assign timed_out = (cnt_reg == TIMEOUT_CYCLES - 16'd1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
        bit_next     = bit_reg;
        frame_next   = frame_reg;
        shift_next   = shift_reg;
        r_data_next  = r_data_reg;
        baud_next    = baud_reg;
        tx_next      = 1'b1;
        r_valid_next = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = 16'd0;
                if (!rxs_reg) begin
                    // The IDLE cycle that saw the line low is the first sync cycle.
                    state_next = S_R_SYNC;
                    cnt_next   = 16'd1;
                end else if (s_valid) begin
                    frame_next = frame_load;
                    state_next = S_T_SYNC;
                end
            end
            S_T_SYNC: begin
                tx_next = 1'b0;
                if (cnt_reg == BAUD_SIZE - 16'd1) begin
                    state_next = S_T_ACK1_LO;
                    cnt_next   = 16'd0;
                end
            end
            S_T_ACK1_LO, S_T_ACK2_LO: begin
                if (!rxs_reg) begin
                    state_next = (state_reg == S_T_ACK1_LO) ? S_T_ACK1_HI : S_T_ACK2_HI;
                    cnt_next   = 16'd0;
                end else if (timed_out) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end
            end
            S_T_ACK1_HI, S_T_ACK2_HI: begin
                if (rxs_reg) begin
                    state_next = (state_reg == S_T_ACK1_HI) ? S_T_GAP : S_IDLE;
                    cnt_next   = 16'd0;
                end else if (timed_out) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end
            end
            S_T_GAP: begin
                if (cnt_reg == BAUD_SIZE - 16'd1) begin
                    state_next = S_T_DATA;
                    cnt_next   = 16'd0;
                    bit_next   = '0;
                end
            end
            S_T_DATA: begin
                tx_next = frame_reg[bit_reg];
                if (cnt_reg == BAUD_SIZE - 16'd1) begin
                    cnt_next = 16'd0;
                    if (bit_reg == LAST_TX_BIT) begin
                        state_next = S_T_ACK2_LO;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            S_R_SYNC: begin
                if (rxs_reg) begin
                    cnt_next = 16'd0;
                    if (cnt_reg < 16'd2) begin
                        state_next = S_IDLE;
                    end else begin
                        baud_next  = cnt_reg;
                        state_next = S_R_ACK1;
                    end
                end
            end
            S_R_ACK1: begin
                tx_next = 1'b0;
                if (cnt_reg == baud_reg - 16'd1) begin
                    state_next = S_R_WAIT_START;
                    cnt_next   = 16'd0;
                end
            end
            S_R_WAIT_START: begin
                if (!rxs_reg) begin
                    state_next = S_R_HALF;
                    cnt_next   = 16'd0;
                end else if (timed_out) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end
            end
            S_R_HALF: begin
                if (cnt_reg == (baud_reg >> 1) - 16'd1) begin
                    cnt_next   = 16'd0;
                    bit_next   = '0;
                    state_next = rxs_reg ? S_R_WAIT_START : S_R_BITS;
                end
            end
            S_R_BITS: begin
                if (cnt_reg == baud_reg - 16'd1) begin
                    cnt_next   = 16'd0;
                    shift_next = {rxs_reg, shift_reg[PACKET_WIDTH-1:1]};
                    if (bit_reg == LAST_RX_BIT) begin
                        state_next = S_R_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            S_R_STOP: begin
                if (cnt_reg == baud_reg - 16'd1) begin
                    cnt_next = 16'd0;
                    if (rxs_reg) begin
                        r_data_next  = shift_reg;
                        r_valid_next = 1'b1;
                        state_next   = S_R_ACK2;
                    end else begin
                        // Framing error is reported on the same pulse as a timeout.
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_R_ACK2: begin
                tx_next = 1'b0;
                if (cnt_reg == BAUD_SIZE - 16'd1) begin
                    state_next = S_IDLE;
                    cnt_next   = 16'd0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 16'd0;
            bit_reg     <= '0;
            frame_reg   <= '0;
            shift_reg   <= '0;
            r_data_reg  <= '0;
            baud_reg    <= 16'd0;
            tx_reg      <= 1'b1;
            r_valid_reg <= 1'b0;
            err_reg     <= 1'b0;
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            frame_reg   <= frame_next;
            shift_reg   <= shift_next;
            r_data_reg  <= r_data_next;
            baud_reg    <= baud_next;
            tx_reg      <= tx_next;
            r_valid_reg <= r_valid_next;
            err_reg     <= err_next;
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    assign tx          = tx_reg;
    assign s_ready     = (state_reg == S_IDLE) && rxs_reg && !rst;
    assign busy        = (state_reg != S_IDLE) && !rst;
    assign r_data      = r_data_reg;
    assign r_valid     = r_valid_reg;
    assign err_timeout = err_reg;
    assign baud_meas   = baud_reg;

endmodule

// File: tb/tb_ext_link_peer.sv
// Bench for ext_link_peer: plays the interface side of the link, with directed
// scenarios followed by randomized send/receive transactions.
module tb_ext_link_peer;

    localparam int PW   = 10;
    localparam int BAUD = 8;
    localparam int TMO  = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx;
    logic          rx;
    logic [PW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] r_data;
    logic          r_valid;
    logic          busy;
    logic          err_timeout;
    logic [15:0]   baud_meas;

    int vectors     = 0;
    int miscompares = 0;
    int run_len     = 0;
    int tx_runs[$];
    int rv_cnt      = 0;
    int err_cnt     = 0;
    int acc_cnt     = 0;
    int exp_baud    = 0;

    always #5 clk = ~clk;

    ext_link_peer dut (
        .clk         (clk),
        .rst         (rst),
        .tx          (tx),
        .rx          (rx),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .busy        (busy),
        .err_timeout (err_timeout),
        .baud_meas   (baud_meas)
    );

    // Line monitor: lengths of completed tx low pulses plus event counters.
    always @(negedge clk) begin
        if (tx === 1'b0) begin
            run_len++;
        end else if (run_len != 0) begin
            tx_runs.push_back(run_len);
            run_len = 0;
        end
        if (r_valid === 1'b1) rv_cnt++;
        if (err_timeout === 1'b1) err_cnt++;
        if (s_valid === 1'b1 && s_ready === 1'b1) acc_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_start(input logic [PW-1:0] d);
        int n;
        int acc0;
        acc0    = acc_cnt;
        s_data  = d;
        s_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (acc_cnt == acc0 && n < 50);
        chk("accept", acc_cnt - acc0, 1);
        s_valid = 1'b0;
        tx_runs.delete();
        chk("busy_after_accept", 32'(busy), 1);
        chk("ready_after_accept", 32'(s_ready), 0);
    endtask

    // Interface side of a transmit: ack the sync, sample the frame mid-bit, ack again.
    task automatic tx_side(input logic [PW-1:0] d, input int ack_len, input int abort_bit);
        int n;
        int len;
        int err0;
        logic [PW+1:0] fr;
        err0 = err_cnt;
        n = 0;
        while (tx_runs.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        chk("sync_seen", 32'(tx_runs.size() != 0), 1);
        if (tx_runs.size() == 0) return;
        len = tx_runs.pop_front();
        chk("sync_len", len, BAUD);
        rx = 1'b0;
        repeat (ack_len) tick();
        rx = 1'b1;
        // 2-cycle synchroniser + detect cycle + BAUD gap + registered tx.
        n = 0;
        do begin
            tick();
            n++;
        end while (tx !== 1'b0 && n < BAUD + 40);
        chk("ack1_gap", n, BAUD + 4);
        fr = '0;
        repeat (BAUD / 2) tick();
        for (int j = 0; j < PW + 2; j++) begin
            if (j > 0) repeat (BAUD) tick();
            fr[j] = tx;
            if (j == abort_bit) return;
        end
        chk("start_bit", 32'(fr[0]), 0);
        chk("stop_bit", 32'(fr[PW+1]), 1);
        chk("tx_data", 32'(fr[PW:1]), 32'(d));
        repeat (BAUD - BAUD / 2) tick();
        rx = 1'b0;
        repeat (ack_len) tick();
        rx = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b0 && n < 40);
        chk("busy_fall", n, 3);
        chk("tx_idle_high", 32'(tx), 1);
        chk("tx_no_err", err_cnt - err0, 0);
        $display("txn send data=%h ack=%0d", d, ack_len);
    endtask

    // Interface side of a receive; with coll set, s_valid rises as rxs falls.
    task automatic recv_pkt(input logic [PW-1:0] d, input int baud, input bit coll,
                            input logic [PW-1:0] td);
        int n;
        int len;
        int rv0;
        int err0;
        int acc0;
        logic [PW+1:0] fr;
        rv0  = rv_cnt;
        err0 = err_cnt;
        acc0 = acc_cnt;
        tx_runs.delete();
        rx = 1'b0;
        for (int i = 1; i < baud; i++) begin
            tick();
            if (coll && i == 1) chk("coll_ready_pre", 32'(s_ready), 1);
            if (coll && i == 2) begin
                chk("coll_ready", 32'(s_ready), 0);
                s_data  = td;
                s_valid = 1'b1;
            end
        end
        tick();
        rx = 1'b1;
        n = 0;
        while (tx_runs.size() == 0 && n < 3 * baud + 20) begin
            tick();
            n++;
        end
        chk("ack1_seen", 32'(tx_runs.size() != 0), 1);
        if (tx_runs.size() == 0) return;
        len = tx_runs.pop_front();
        chk("ack1_len", len, baud);
        chk("baud_meas", 32'(baud_meas), baud);
        exp_baud = baud;
        if (coll) chk("coll_hold", acc_cnt - acc0, 0);
        repeat ($urandom_range(0, baud)) tick();
        fr = {1'b1, d, 1'b0};
        for (int j = 0; j < PW + 2; j++) begin
            rx = fr[j];
            repeat (baud) tick();
        end
        rx = 1'b1;
        n = 0;
        while (tx_runs.size() == 0 && n < 2 * baud + BAUD + 40) begin
            tick();
            n++;
        end
        chk("ack2_seen", 32'(tx_runs.size() != 0), 1);
        if (tx_runs.size() == 0) return;
        len = tx_runs.pop_front();
        chk("ack2_len", len, BAUD);
        chk("r_data", 32'(r_data), 32'(d));
        chk("r_valid_pulses", rv_cnt - rv0, 1);
        chk("rx_no_err", err_cnt - err0, 0);
        if (!coll) chk("rx_idle", 32'(busy), 0);
        $display("txn recv data=%h baud=%0d", d, baud);
    endtask

    initial begin
        #800000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int err0;
        int acc0;
        int rv0;
        logic [PW-1:0] d;

        rst     = 1'b1;
        rx      = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx), 1);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_r_data", 32'(r_data), 0);
        chk("rst_r_valid", 32'(r_valid), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_baud", 32'(baud_meas), 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(s_ready), 1);

        send_start(10'h2A5);
        tx_side(10'h2A5, 8, -1);

        recv_pkt(10'h0C3, 12, 1'b0, 10'h000);

        // Collision: receive wins, queued send goes out once IDLE returns.
        acc0 = acc_cnt;
        recv_pkt(10'h1F0, 10, 1'b1, 10'h35A);
        chk("coll_accept", acc_cnt - acc0, 1);
        s_valid = 1'b0;
        tx_runs.delete();
        tx_side(10'h35A, 8, -1);

        // One-cycle glitch on rx.
        err0 = err_cnt;
        rv0  = rv_cnt;
        tx_runs.delete();
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (20) tick();
        chk("glitch_no_ack", tx_runs.size(), 0);
        chk("glitch_no_err", err_cnt - err0, 0);
        chk("glitch_no_rv", rv_cnt - rv0, 0);
        chk("glitch_idle", 32'(busy), 0);
        chk("glitch_baud", 32'(baud_meas), exp_baud);
        $display("txn glitch");

        // No ack: watchdog abort, counted from entry into the ack wait.
        send_start(10'h0F0);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin tick(); n++; end
        n = 0;
        while (tx !== 1'b1 && n < 40) begin tick(); n++; end
        err0 = err_cnt;
        n = 0;
        do begin
            tick();
            n++;
        end while (err_timeout !== 1'b1 && n < TMO + 20);
        chk("timeout_latency", n, TMO - 1);
        chk("timeout_tx", 32'(tx), 1);
        tick();
        chk("timeout_pulse_width", 32'(err_timeout), 0);
        chk("timeout_idle", 32'(busy), 0);
        chk("timeout_count", err_cnt - err0, 1);
        $display("txn timeout");

        // Reset while frame bit 5 (a 0 for this packet) is on the line.
        send_start(10'h2A5);
        tx_side(10'h2A5, 8, 5);
        chk("pre_rst_tx_low", 32'(tx), 0);
        rv0 = rv_cnt;
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        chk("mid_rst_r_data", 32'(r_data), 0);
        chk("mid_rst_err", 32'(err_timeout), 0);
        chk("mid_rst_baud", 32'(baud_meas), 0);
        exp_baud = 0;
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(s_ready), 1);
        chk("post_rst_no_rv", rv_cnt - rv0, 0);
        $display("txn reset");
        send_start(10'h155);
        tx_side(10'h155, 8, -1);

        for (int k = 0; k < 12; k++) begin
            d = PW'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                n = int'($urandom_range(1, 16));
                send_start(d);
                tx_side(d, n, -1);
            end else begin
                recv_pkt(d, int'($urandom_range(4, 16)), 1'b0, 10'h000);
            end
            repeat ($urandom_range(1, 5)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ext_link_peer.md
Name: ext_link_peer

Overview:
- Far-end transceiver for the external serial link into the bus-side external interface. It is the peer that sits off-chip or in the testbench harness.
- Transmit direction: sends 10-bit packets using the link's sync-pulse / ack / framed-data / ack handshake.
- Receive direction: answers the interface's sync pulse, deserialises the framed packet and acknowledges it.
- Provides a valid/ready parallel port to local logic and flags handshake timeouts.

Parameters:
- PACKET_WIDTH, 10, bits per data frame (prefix bits plus data byte).
- BAUD_SIZE, 16'd8, clk cycles per bit period. This is also the sync-pulse length driven on transmit. Must be ≥ 4.
- TIMEOUT_CYCLES, 16'd4096, maximum clk cycles spent waiting for any ack edge or start bit before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tx  out  1  serial line to the interface's rx. Idles high.
- rx  in  1  serial line from the interface's tx. Idles high; asynchronous.
- s_data  in  PACKET_WIDTH  packet to send.
- s_valid  in  1  send request.
- s_ready  out  1  high in IDLE only. A packet is accepted on the cycle where s_valid and s_ready are both high.
- r_data  out  PACKET_WIDTH  last received packet.
- r_valid  out  1  one-cycle pulse when r_data updates.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on any timeout abort.
- baud_meas  out  16  low-cycle count measured on the last received sync pulse.

Behaviour:
- Reset values:
  - tx=1, s_ready=0 during rst and 1 in the first cycle after rst deasserts.
  - r_data=0, r_valid=0, busy=0, err_timeout=0, baud_meas=0.
  - state=IDLE, all counters 0.
- rx synchronisation:
  - rx passes through a 2-flop synchroniser; rxs below is the synchronised value.
  - All rx timing is relative to rxs.
- tx drive: tx is driven from a register, so a state's tx value appears one cycle after entry.
- Bit order and framing:
  - Data is LSB first.
  - Frame = start bit (0), PACKET_WIDTH data bits, stop bit (1).
  - Each bit lasts exactly BAUD_SIZE cycles.
- IDLE arbitration:
  - If rxs==0, go to R_SYNC. This has priority over a same-cycle s_valid; s_ready is low that cycle.
  - Else if s_valid, latch s_data and go to T_SYNC.
- Transmit path:
  - T_SYNC: tx=0 for BAUD_SIZE cycles, then tx=1 and go to T_ACK1_LO.
  - T_ACK1_LO: wait for rxs==0, then go to T_ACK1_HI.
  - T_ACK1_HI: wait for rxs==1, then go to T_GAP.
  - T_GAP: hold tx=1 for BAUD_SIZE cycles.
  - T_DATA: shift the start bit, PACKET_WIDTH data bits and stop bit onto tx using a bit counter 0..PACKET_WIDTH+1.
  - T_ACK2_LO, then T_ACK2_HI: same edge waits as the first ack, then return to IDLE.
- Receive path:
  - R_SYNC: count cycles with rxs==0, starting from 1. On rxs==1, store the count in baud_meas and go to R_ACK1.
  - Sync shorter than 2 cycles: treated as a glitch; return to IDLE with no ack and no error.
  - Sync count saturates at 16'hFFFF.
  - R_ACK1: tx=0 for baud_meas cycles, then tx=1.
  - R_WAIT_START: wait for rxs==0.
  - R_HALF: wait baud_meas/2 cycles (integer floor), then resample. If rxs==1 it is a false start; return to R_WAIT_START.
  - R_BITS: sample every baud_meas cycles, PACKET_WIDTH times, assembling LSB first.
  - R_STOP: one further sample. If it reads 1, assert r_data/r_valid and go to R_ACK2. If it reads 0, it is a framing error: drop the packet, assert err_timeout, return to IDLE.
  - R_ACK2: tx=0 for BAUD_SIZE cycles, then tx=1 and return to IDLE.
  - Receive timing uses baud_meas, not BAUD_SIZE, everywhere except R_ACK2, because the link rate is set by the sender's sync pulse.
- Timeouts:
  - A single watchdog counter clears on every state entry.
  - In any wait-for-edge state (ACK_LO/HI, R_WAIT_START), reaching TIMEOUT_CYCLES triggers an abort: tx=1, err_timeout pulses, return to IDLE.
- Reset mid-operation: rst aborts any state immediately. tx returns high on the next cycle and no r_valid is produced.
- Back-to-back: IDLE lasts at least 1 cycle between transactions.

Test Plan:
- Send s_data=10'h2A5, with a model interface that acks with an 8-cycle low pulse and samples mid-bit:
  - tx low exactly 8 cycles, then 8-cycle gap after the ack.
  - Bits 1,0,1,0,0,1,0,1,0,1 (LSB first) between start 0 and stop 1.
  - busy falls after the second ack.
- Interface sends a 12-cycle sync, then frame 10'h0C3 at 12 cycles/bit:
  - baud_meas=12.
  - 12-cycle ack low.
  - r_data=10'h0C3 with a single r_valid pulse.
  - 8-cycle second ack.
- rxs falls on the same cycle as s_valid=1: receive wins, s_ready=0, and the transmit packet is sent only after IDLE is re-entered.
- Send with no ack from the interface: err_timeout pulses exactly TIMEOUT_CYCLES after the wait started, tx=1, and the block returns to IDLE.
- 1-cycle rx glitch in IDLE: no ack on tx, no error, state stays IDLE.
- Assert rst during T_DATA bit 5: tx=1 on the next cycle, all outputs at reset values, and a following send of 10'h155 completes normally.
